// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Start + 8 data + parity + stop.
  localparam int unsigned FrameBits = 11;
  localparam int unsigned DataBits  = FrameBits - 3;
  localparam logic        IdleData  = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead FIFO with extra-MSB pointers; reports pushes dropped while full.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot, so a full FIFO can still take a push that cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a byte FIFO with sticky overflow.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned   TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LastBit = 3'(DataBits - 1);

  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       pdat_s1_q, pdat_s2_q;
  logic       fall;

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            push;
  logic            drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pclk_s1_q <= 1'b1;
      pclk_s2_q <= 1'b1;
      pclk_s3_q <= 1'b1;
      pdat_s1_q <= 1'b1;
      pdat_s2_q <= 1'b1;
    end else begin
      pclk_s1_q <= ps2_clk;
      pclk_s2_q <= pclk_s1_q;
      pclk_s3_q <= pclk_s2_q;
      pdat_s1_q <= ps2_data;
      pdat_s2_q <= pdat_s1_q;
    end
  end

  assign fall = pclk_s3_q & ~pclk_s2_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    push      = 1'b0;
    case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (fall && !pdat_s2_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {pdat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LastBit) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = pdat_s2_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          if (pdat_s2_q == IdleData && (^{shift_q, par_q})) push  = 1'b1;
          else                                               err_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort a stalled frame; any clock edge restarts the idle count.
    if (state_q != StIdle) begin
      if (fall) begin
        tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
        state_d   = StIdle;
        bit_cnt_d = '0;
        shift_d   = '0;
        tmo_d     = '0;
        err_d     = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clr_err) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (push),
    .wdata_i(shift_q),
    .pop_i  (rd_en),
    .rdata_o(rd_data),
    .empty_o(empty),
    .full_o (full),
    .drop_o (drop)
  );

  assign overflow  = ovf_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed plus randomized PS/2 frames checked against a queue-based reference model.
module tb_ps2_rx_fifo;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 50000;
  localparam int          H     = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_data, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       empty, full, overflow, frame_err;

  int compared = 0;
  int mismatched = 0;
  int err_seen = 0;
  int err_exp  = 0;

  logic [7:0] q[$];
  logic       ovf_exp;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH    (Depth),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always @(negedge clk) if (frame_err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == Depth));
    check({tag, ".ovf"}, 32'(overflow), 32'(ovf_exp));
    check({tag, ".data"}, 32'(rd_data), (q.size() == 0) ? 32'h0 : 32'(q[0]));
    check({tag, ".errs"}, 32'(err_seen), 32'(err_exp));
  endtask

  // Sends the first n bits of a frame, LSB (start bit) first.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_last);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_last && i == n - 1) begin
        // Edge is detected two clk cycles after the drive; pop lands on the push cycle.
        repeat (2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (H - 3) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // Sends a whole frame and updates the model from the protocol rules.
  task automatic frame(input logic [7:0] b, input bit par_flip, input bit stop,
                       input bit pop_at_stop);
    logic par;
    par = (~^b) ^ par_flip;
    send_bits({stop, par, b, 1'b0}, 11, pop_at_stop);
    if (pop_at_stop && q.size() != 0) void'(q.pop_front());
    if (par_flip || !stop)      err_exp++;
    else if (q.size() == Depth) ovf_exp = 1'b1;
    else                        q.push_back(b);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q.delete();
    ovf_exp = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    do_reset();
    check_state("reset");

    frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_state("valid_1c");
    pop_one();
    check_state("pop_1c");

    frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check_state("bad_parity");
    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_state("bad_stop");

    pop_one();
    check_state("pop_empty");
    frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check_state("after_empty_pop");
    pop_one();

    frame(8'h11, 0, 1, 0); frame(8'h22, 0, 1, 0); frame(8'h33, 0, 1, 0);
    frame(8'h44, 0, 1, 0); frame(8'h55, 0, 1, 0);
    check_state("overflow");
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; ovf_exp = 1'b0;
    check_state("clr_err");
    for (int i = 0; i < 4; i++) begin
      pop_one();
      check_state("drain");
    end

    for (int i = 0; i < 4; i++) frame(8'($urandom), 0, 1, 0);
    check_state("refill");
    frame(8'hE0, 0, 1, 1);
    check_state("push_pop_full");
    for (int i = 0; i < 4; i++) begin
      pop_one();
      check_state("drain2");
    end

    for (int i = 0; i < 12; i++) begin
      frame(8'($urandom), $urandom_range(3) == 0, 1'b1, 1'b0);
      if ($urandom_range(1) == 1) pop_one();
      check_state("random");
    end
    while (q.size() != 0) pop_one();
    ovf_exp = overflow;  // random phase may or may not have overflowed; resync then clear
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; ovf_exp = 1'b0;
    check_state("random_done");

    send_bits(11'b000_0000_0000, 4, 1'b0);
    repeat (Tmo - 100) @(negedge clk);
    check_state("tmo_early");
    repeat (200) @(negedge clk);
    err_exp++;
    check_state("tmo_abort");
    frame(8'hF0, 0, 1, 0);
    check_state("after_tmo");
    pop_one();

    send_bits({1'b1, 1'b1, 8'hAA, 1'b0}, 5, 1'b0);
    do_reset();
    check_state("mid_reset");
    frame(8'h5A, 0, 1, 0);
    check_state("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of received bytes buffered (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle clk cycles inside a frame before abort (1 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock, the one clock of the block.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the connector, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from the connector, asynchronous.
REQ-007 SHALL have port rd_en  input  1  CPU pop strobe, one byte per cycle high.
REQ-008 SHALL have port clr_err  input  1  clears the sticky overflow flag.
REQ-009 SHALL have port rd_data  output  8  head-of-FIFO scan code, show-ahead.
REQ-010 SHALL have port empty  output  1  FIFO holds no bytes.
REQ-011 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-012 SHALL have port overflow  output  1  sticky, a byte was dropped.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-014 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer, then detect ps2_clk falling edges by comparing against a third registered copy.
REQ-015 SHALL sample synchronized ps2_data only in cycles where a falling edge is detected.
REQ-016 SHALL run the FSM IDLE -> DATA -> PARITY -> STOP -> IDLE.
REQ-017 SHALL, in IDLE, enter DATA on an edge with data=0 (start bit); an edge with data=1 SHALL be ignored.
REQ-018 SHALL, in DATA, shift 8 bits LSB first; the bit counter (3 bits) SHALL wrap 7->0 and move to PARITY.
REQ-019 SHALL, in PARITY, sample the parity bit; odd parity over 8 data bits plus parity is correct.
REQ-020 SHALL, in STOP, sample the stop bit, then push the byte when stop=1 and parity is correct, or else pulse frame_err for one cycle without pushing; either way return to IDLE.
REQ-021 SHALL, in any non-IDLE state, count clk cycles since the last edge and, on reaching TIMEOUT_CYCLES, go to IDLE, discard partial data and pulse frame_err.
REQ-022 SHALL push in the cycle the stop-bit edge is detected; empty SHALL deassert the following cycle.
REQ-023 SHALL drive rd_data with the head entry whenever not empty, and with 8'h00 when empty.
REQ-024 SHALL pop on rd_en when not empty; rd_en while empty SHALL be ignored with no pointer change.
REQ-025 SHALL drop a push when full and no pop occurs in the same cycle, and set overflow.
REQ-026 SHALL accept both a push and a pop on a full FIFO in the same cycle, leaving count unchanged and overflow untouched.
REQ-027 SHALL hold overflow until a clr_err cycle; if clr_err and a new overflow coincide, overflow SHALL remain set.
REQ-028 SHALL use read/write pointers one bit wider than log2(FIFO_DEPTH) for full/empty; pointers wrap naturally.
REQ-029 SHALL forward raw bytes, including F0/E0 prefixes, with no scan-code decoding.

Reset
REQ-030 SHALL, on reset, force FSM=IDLE, bit counter=0, timeout counter=0, pointers=0, synchronizer flops=1, overflow=0 and frame_err=0; rd_data=00, empty=1, full=0.
REQ-031 SHALL, when reset is asserted mid-frame, discard the frame; after release, reception SHALL restart only on a new start bit.

Structure
REQ-032 SHALL place the FSM state enum, the PS/2 frame length constant (11) and the idle data value in package ps2_pkg.
REQ-033 SHALL place the FIFO storage and pointers in sub-module byte_fifo (params DEPTH, WIDTH=8); the frame receiver SHALL stay in ps2_rx_fifo.

Verification
REQ-034 SHALL cover a valid frame: byte 8'h1C, parity 0, stop 1 -> rd_data=1C, empty=0, frame_err never pulses.
REQ-035 SHALL cover a bad frame: byte 8'h1C with parity 1 -> frame_err one pulse, empty stays 1.
REQ-036 SHALL cover overflow: 5 valid frames (11,22,33,44,55), no pops, depth 4 -> full=1, overflow=1, pops yield 11,22,33,44 then empty=1.
REQ-037 SHALL cover timeout: start bit plus 3 data bits, then ps2_clk held high for 50000 cycles -> frame_err pulse, FSM IDLE, next full frame 8'hF0 received intact.
REQ-038 SHALL cover full with simultaneous push and pop: stop edge coincides with rd_en -> count stays 4, overflow=0, order preserved.
REQ-039 SHALL cover mid-frame reset: reset asserted after bit 4 of 8'hAA -> after release, empty=1; next frame 8'h5A yields rd_data=5A.
